// File: rtl/cblp_bram_pkg.sv
// rtl/cblp_bram_pkg.sv - shared widths, FSM states and request record for the CBLP BRAM arbiter
package cblp_bram_pkg;

    localparam int CBLP_DATA_W = 64;
    localparam int CBLP_ADDR_W = 14;
    localparam logic [CBLP_ADDR_W-1:0] CBLP_MAX_ADDR = 14'h3FFE;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ACCESS,
        DONE,
        GAP
    } arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [CBLP_ADDR_W-1:0] addr;
        logic [CBLP_DATA_W-1:0] wdata;
    } bram_req_t;

endpackage

// File: rtl/cblp_rr_arb2.sv
// rtl/cblp_rr_arb2.sv - two-way grant; round-robin, or fixed port-0 priority with CBLP_BRAM_ARB_FIXED_PRIO_EN
module cblp_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef CBLP_BRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (req[0])
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end
`else
    logic ptr;

    // ptr names the port that wins a tie; it flips after every grant, rejected ones included
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (advance && (req != 2'b00))
            ptr <= ~ptr;
    end
`endif

endmodule

// File: rtl/cblp_bram_arbiter.sv
// rtl/cblp_bram_arbiter.sv - two-port arbiter sequencing timed cs/wbit windows onto one BRAM
// CBLP_BRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module cblp_bram_arbiter
    import cblp_bram_pkg::*;
#(
    parameter int                DATA_W        = CBLP_DATA_W,
    parameter int                ADDR_W        = CBLP_ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR      = CBLP_MAX_ADDR,
    parameter int                ACCESS_CYCLES = 4,
    parameter int                GAP_CYCLES    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              bram_cs,
    output logic              bram_wbit,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    arb_state_t state;
    bram_req_t  req_in;
    bram_req_t  req_q;
    logic [1:0] grant;
    logic       win;
    logic       port_q;
    logic [7:0] cnt;

    cblp_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (state == IDLE),
        .grant   (grant)
    );

    assign win       = grant[1];
    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;

    always_comb begin
        req_in.we    = win ? req_we[1]  : req_we[0];
        req_in.addr  = win ? req_addr1  : req_addr0;
        req_in.wdata = win ? req_wdata1 : req_wdata0;
    end

    // The range check is made on the grant edge so a rejection answers during CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            port_q     <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= 2'b00;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            bram_cs    <= 1'b0;
            bram_wbit  <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        req_q  <= req_in;
                        port_q <= win;
                        if (req_in.addr > MAX_ADDR) begin
                            rsp_valid <= grant;
                            rsp_err   <= 1'b1;
                        end
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    cnt <= 8'd1;
                    if (rsp_err) begin
                        rsp_valid <= 2'b00;
                        rsp_err   <= 1'b0;
                        state     <= GAP;
                    end else begin
                        bram_addr  <= req_q.addr;
                        bram_wdata <= req_q.wdata;
                        bram_cs    <= 1'b1;
                        bram_wbit  <= req_q.we;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 8'(ACCESS_CYCLES)) begin
                        rsp_rdata <= bram_rdata;
                        bram_cs   <= 1'b0;
                        bram_wbit <= 1'b0;
                        rsp_valid <= port_q ? 2'b10 : 2'b01;
                        rsp_err   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    rsp_valid <= 2'b00;
                    cnt       <= 8'd1;
                    state     <= GAP;
                end
                GAP: begin
                    if (cnt == 8'(GAP_CYCLES))
                        state <= IDLE;
                    else
                        cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cblp_bram_arbiter.sv
// tb/tb_cblp_bram_arbiter.sv - scoreboard bench for cblp_bram_arbiter with a behavioural BRAM
module tb_cblp_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = 2'b00;
    logic [13:0] req_addr0 = '0;
    logic [13:0] req_addr1 = '0;
    logic [63:0] req_wdata0 = '0;
    logic [63:0] req_wdata1 = '0;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;
    logic        bram_cs;
    logic        bram_wbit;
    logic [13:0] bram_addr;
    logic [63:0] bram_wdata;
    logic [63:0] bram_rdata = '0;

    typedef struct {
        int          port;
        logic        err;
        logic        rd;
        logic [63:0] rdata;
        int          due;
    } exp_t;

    typedef struct {
        logic [13:0] addr;
        logic        we;
        logic [63:0] wdata;
    } acc_t;

    exp_t        sb[$];
    acc_t        aq[$];
    logic [63:0] mem[int];
    logic [63:0] shadow[int];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    cblp_bram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .bram_cs    (bram_cs),
        .bram_wbit  (bram_wbit),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // BRAM model: read data registered one edge after cs is seen, write on cs&wbit
    initial forever begin
        @(posedge clk);
        if (bram_cs) begin
            bram_rdata <= mem.exists(int'(bram_addr)) ? mem[int'(bram_addr)] : 64'h0;
            if (bram_wbit)
                mem[int'(bram_addr)] = bram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] shadow_rd(input logic [13:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : 64'h0;
    endfunction

    // Monitor: responses against the scoreboard, cs windows against the access queue
    initial begin
        logic cs_prev = 1'b0;
        logic abort   = 1'b0;
        int   cs_len  = 0;
        int   gap     = 100;
        acc_t cur;
        exp_t e;
        cur = '{addr: '0, we: 1'b0, wdata: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                abort = bram_cs;
                gap   = 100;
            end else begin
                if (rsp_valid != 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_port", 64'(rsp_valid), (e.port == 1) ? 64'h2 : 64'h1);
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        chk("rsp_latency", 64'(cyc), 64'(e.due));
                        if (e.rd)
                            chk("rsp_rdata", rsp_rdata, e.rdata);
                    end
                end
                if (bram_cs && !cs_prev) begin
                    chk("cs_gap_ge5", 64'(gap >= 5), 64'h1);
                    if (aq.size() == 0)
                        chk("cs_unexpected", 64'(bram_cs), 64'h0);
                    else
                        cur = aq.pop_front();
                    cs_len = 0;
                    abort  = 1'b0;
                end
                if (!bram_cs && cs_prev) begin
                    if (!abort)
                        chk("cs_len", 64'(cs_len), 64'd4);
                    gap = abort ? 100 : 0;
                end
                if (bram_cs) begin
                    cs_len++;
                    chk("bram_addr", 64'(bram_addr), 64'(cur.addr));
                    chk("bram_wdata", bram_wdata, cur.wdata);
                    chk("bram_wbit", 64'(bram_wbit), 64'(cur.we));
                end else begin
                    chk("wbit_without_cs", 64'(bram_wbit), 64'h0);
                    gap++;
                end
            end
            cs_prev = bram_cs;
        end
    end

    task automatic push_exp(input int p, input logic we, input logic [13:0] a, input logic [63:0] d);
        logic err;
        err = (a > 14'h3FFE);
        sb.push_back('{port: p, err: err, rd: !we && !err, rdata: shadow_rd(a),
                       due: cyc + (err ? 1 : 6)});
        if (!err) begin
            aq.push_back('{addr: a, we: we, wdata: d});
            if (we)
                shadow[int'(a)] = d;
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [13:0] a, input logic [63:0] d);
        int t = 0;
        req_we[p] = we;
        if (p == 0) begin
            req_addr0  = a;
            req_wdata0 = d;
        end else begin
            req_addr1  = a;
            req_wdata1 = d;
        end
        req_valid[p] = 1'b1;
        #1;
        while (!req_ready[p] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("issue_ready_seen", 64'(t < 100), 64'h1);
        push_exp(p, we, a, d);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(sb.size()), 64'h0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int   t;
        int   last;
        int   p;
        int   exp_p;
        logic [63:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_err", 64'(rsp_err), 64'h0);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_cs", 64'(bram_cs), 64'h0);
        chk("rst_wbit", 64'(bram_wbit), 64'h0);
        chk("rst_addr", 64'(bram_addr), 64'h0);
        chk("rst_wdata", bram_wdata, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // single write then readback from the other port
        issue(0, 1'b1, 14'h0000, 64'hAABBCCDDEEFF9988);
        drain();
        issue(1, 1'b0, 14'h0000, 64'h0);
        drain();

        // top legal address, then the first illegal one
        issue(0, 1'b1, 14'h3FFE, 64'h0123456789ABCDEF);
        drain();
        issue(1, 1'b1, 14'h3FFF, 64'hFFFF0000FFFF0000);
        drain();
        issue(0, 1'b0, 14'h3FFE, 64'h0);
        drain();

        // both ports held valid from a fresh reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_we = 2'b00;
        req_addr0 = 14'h0000;
        req_addr1 = 14'h3FFE;
        req_wdata0 = '0;
        req_wdata1 = '0;
        req_valid = 2'b11;
        #1;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            t = 0;
            while (req_ready == 2'b00 && t < 100) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("arb_ready_seen", 64'(t < 100), 64'h1);
            p = req_ready[1] ? 1 : 0;
`ifdef CBLP_BRAM_ARB_FIXED_PRIO_EN
            exp_p = 0;
`else
            exp_p = g % 2;
`endif
            chk("arb_grant_port", 64'(p), 64'(exp_p));
            if (g > 0)
                chk("arb_spacing", 64'(cyc - last), 64'd12);
            last = cyc;
            push_exp(p, 1'b0, (p == 1) ? 14'h3FFE : 14'h0000, 64'h0);
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        drain();

        // reset during the second ACCESS cycle of a port-0 write
        req_we[0] = 1'b1;
        req_addr0 = 14'h0010;
        req_wdata0 = 64'h5555AAAA5555AAAA;
        req_valid[0] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[0] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("rstmid_ready_seen", 64'(t < 100), 64'h1);
        aq.push_back('{addr: 14'h0010, we: 1'b1, wdata: 64'h5555AAAA5555AAAA});
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_cs", 64'(bram_cs), 64'h0);
        chk("rstmid_wbit", 64'(bram_wbit), 64'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid_no_rsp", 64'(sb.size()), 64'h0);
        req_we = 2'b00;
        req_addr0 = 14'h0000;
        req_addr1 = 14'h3FFE;
        req_wdata0 = '0;
        req_wdata1 = '0;
        req_valid = 2'b11;
        #1;
        t = 0;
        while (req_ready == 2'b00 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("rstmid_grant_port0", 64'(req_ready), 64'h1);
        push_exp(0, 1'b0, 14'h0000, 64'h0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain();

        // sequential address walk on port 0, low end and top end of the range
        for (int a = 0; a < 32; a++) begin
            d = {32'hC0DE0000, 32'(a)};
            issue(0, 1'b1, 14'(a), d);
        end
        for (int a = 16'h3FE0; a <= 16'h3FFE; a++) begin
            d = {32'hBEEF0000, 32'(a)};
            issue(0, 1'b1, 14'(a), d);
        end
        drain();
        issue(1, 1'b0, 14'h0005, 64'h0);
        issue(1, 1'b0, 14'h3FF7, 64'h0);
        drain();
        chk("walk_queue_empty", 64'(aq.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
